// File: rtl/add32_result_collector_if.sv
// Bundle between the 32-bit pipelined adder side, the consumer and the result collector.
// `new` is a reserved word in SystemVerilog, so the adder's flush/new net is carried as `flush`.
interface add32_result_collector_if #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8
);
  logic                            issue;
  logic                            stop;
  logic                            flush;
  logic [WIDTH-1:0]                sum;
  logic                            cout;
  logic                            rd_en;
  logic [WIDTH:0]                  rd_data;
  logic                            empty;
  logic                            full;
  logic [$clog2(DEPTH):0]          count;
  logic [$clog2(LATENCY+1)-1:0]    inflight;
  logic                            overflow;

  modport master (
    output issue, stop, flush, sum, cout, rd_en,
    input  rd_data, empty, full, count, inflight, overflow
  );

  modport slave (
    input  issue, stop, flush, sum, cout, rd_en,
    output rd_data, empty, full, count, inflight, overflow
  );
endinterface

// File: rtl/add32_result_collector.sv
// Result collector for the pipelined adder: tracks valid tags alongside the adder pipeline
// and queues each real {cout, sum} into a show-ahead FIFO drained by rd_en.
module add32_result_collector #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8
) (
  input logic                     clk,
  input logic                     rst,
  add32_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] vld_reg;
  logic [LATENCY-1:0] vld_next;
  logic [WIDTH:0]     mem [DEPTH];
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic               empty_reg;
  logic               full_reg;
  logic               overflow_reg;
  logic [IW-1:0]      inflight_sum;

  logic cap;
  logic pop;
  logic wr;
  logic drop;

  // Shifted tag vector; bit 0 takes the new issue, the oldest tag falls off the top.
  assign vld_next[0] = bus.issue;
  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_tag_shift
      assign vld_next[gi] = vld_reg[gi-1];
    end
  endgenerate

  assign cap  = vld_reg[LATENCY-1] & ~bus.stop & ~bus.flush;
  assign pop  = bus.rd_en & ~empty_reg;
  // A pop on the same edge frees the head slot, so a full FIFO can still accept.
  assign wr   = cap & (~full_reg | pop);
  assign drop = cap & full_reg & ~pop;

  always_comb begin
    count_next = count_reg;
    if (wr && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !wr) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_comb begin
    inflight_sum = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_sum = inflight_sum + IW'(vld_reg[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg      <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (bus.flush) begin
        vld_reg <= '0;
      end else if (!bus.stop) begin
        vld_reg <= vld_next;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == CW'(DEPTH));
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Storage carries no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem[wr_ptr_reg] <= {bus.cout, bus.sum};
    end
  end

  assign bus.rd_data  = empty_reg ? '0 : mem[rd_ptr_reg];
  assign bus.empty    = empty_reg;
  assign bus.full     = full_reg;
  assign bus.count    = count_reg;
  assign bus.inflight = inflight_sum;
  assign bus.overflow = overflow_reg;
endmodule
